spi_byte_shifter: RTL

//  SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first, one byte per transfer.

---
 rtl/spi_byte_shifter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master shift engine: one MSB-first byte per transfer, CS setup/hold
// of one SCLK half-period each, received byte returned with a done pulse.
module spi_byte_shifter #(
  parameter int HALF_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_data_o
);

  // state | meaning
  // IDLE  | waiting for start_i, CS released
  // LEAD  | CS asserted, SCLK low for one half-period (setup)
  // SHIFT | 16 SCLK half-periods, low phase first
  // TRAIL | CS still asserted, SCLK low for one half-period (hold)
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  localparam int CW = $clog2(HALF_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cnt_end;

  assign cnt_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_end ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          // bit 7 goes straight to mosi; only the remaining bits need storing
          tx_d    = tx_data_i[6:0];
          mosi_d  = tx_data_i[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = 3'd0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt_end) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], miso_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = TRAIL;
            end else begin
              mosi_d = tx_q[6];
              tx_d   = {tx_q[5:0], 1'b0};
              bit_d  = bit_q + 3'd1;
            end
          end
        end
      end
      TRAIL: begin
        if (cnt_end) begin
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      tx_q      <= 7'd0;
      rx_q      <= 8'h00;
      rx_data_q <= 8'h00;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;

endmodule
